sonar_ranger: RTL and testbench



---
 rtl/sonar_pkg.sv | 22 ++
 rtl/sonar_ranger_if.sv | 29 ++
 rtl/echo_sync.sv | 32 +++
 rtl/sonar_ranger.sv | 166 ++++++++++++++++
 tb/tb_sonar_ranger.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared ranging definitions: FSM states and default timing constants,
// used by both the sensor-side ranger and the cutting controller.
package sonar_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE
   } state_t;

   localparam int DIS_LEN        = 16;
   localparam int TRIG_CYCLES    = 500;
   localparam int CYC_PER_UNIT   = 292;
   localparam int TIMEOUT_CYCLES = 1_500_000;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sonar_ranger_if.sv
// Controller <-> ranger handshake: level request in, one-cycle ack and
// result strobe out with the measured distance.
interface sonar_ranger_if #(
   parameter int DisLen = 16
);

   logic              trigger;
   logic              triggerSuc;
   logic              valid;
   logic              timeout;
   logic [DisLen:0]   distance;

   modport master (
      output trigger,
      input  triggerSuc,
      input  valid,
      input  timeout,
      input  distance
   );

   modport slave (
      input  trigger,
      output triggerSuc,
      output valid,
      output timeout,
      output distance
   );

endinterface

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous sensor echo pin, plus
// single-cycle rise/fall detection on the synchronised level.
module echo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic echo,
   output logic rise,
   output logic fall,
   output logic level
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
         prev_reg <= 1'b0;
      end else begin
         meta_reg <= echo;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign level = sync_reg;
   assign rise  = sync_reg & ~prev_reg;
   assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/sonar_ranger.sv
// Sensor-side ranging engine: issues the TRIG pulse, times the echo-high
// interval in distance units and reports result or timeout to the controller.
module sonar_ranger #(
   parameter int DisLen         = 16,
   parameter int TRIG_CYCLES    = sonar_pkg::TRIG_CYCLES,
   parameter int CYC_PER_UNIT   = sonar_pkg::CYC_PER_UNIT,
   parameter int TIMEOUT_CYCLES = sonar_pkg::TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sonar_ranger_if.slave        bus,
   output logic                 sensor_trig,
   input  logic                 echo
);

   import sonar_pkg::*;

   localparam int TRIG_W = cnt_width(TRIG_CYCLES);
   localparam int PRE_W  = cnt_width(CYC_PER_UNIT);
   localparam int TO_W   = cnt_width(TIMEOUT_CYCLES);

   localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYC_PER_UNIT - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DisLen:0]   DIST_MAX  = '1;

   state_t              state_reg, state_next;
   logic [TRIG_W-1:0]   trig_cnt_reg, trig_cnt_next;
   logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
   logic [PRE_W-1:0]    pre_reg, pre_next;
   logic [DisLen:0]     acc_reg, acc_next;
   logic [DisLen:0]     dist_reg, dist_next;
   logic                sensor_trig_reg, sensor_trig_next;
   logic                suc_reg, suc_next;
   logic                valid_reg, valid_next;
   logic                timeout_reg, timeout_next;

   logic                echo_rise;
   logic                echo_fall;
   logic                echo_level;
   logic                to_expire;
   logic                pre_wrap;
   logic [PRE_W-1:0]    pre_step;
   logic [DisLen:0]     acc_step;

   echo_sync u_echo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .echo  (echo),
      .rise  (echo_rise),
      .fall  (echo_fall),
      .level (echo_level)
   );

   // One synchronised-high clock: advance the prescaler, bump the saturating
   // accumulator each time it wraps.
   assign to_expire = (to_cnt_reg == TO_LAST);
   assign pre_wrap  = (pre_reg == PRE_LAST);
   assign pre_step  = pre_wrap ? '0 : pre_reg + 1'b1;
   assign acc_step  = (pre_wrap && acc_reg != DIST_MAX) ? acc_reg + 1'b1 : acc_reg;

   always_comb begin
      state_next       = state_reg;
      trig_cnt_next    = trig_cnt_reg;
      to_cnt_next      = to_cnt_reg;
      pre_next         = pre_reg;
      acc_next         = acc_reg;
      dist_next        = dist_reg;
      sensor_trig_next = 1'b0;
      suc_next         = 1'b0;
      valid_next       = 1'b0;
      timeout_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            trig_cnt_next = '0;
            to_cnt_next   = '0;
            pre_next      = '0;
            acc_next      = '0;
            if (bus.trigger) begin
               state_next       = TRIG;
               sensor_trig_next = 1'b1;
            end
         end

         TRIG: begin
            if (trig_cnt_reg == TRIG_LAST) begin
               state_next = WAIT_RISE;
               suc_next   = 1'b1;
            end else begin
               trig_cnt_next    = trig_cnt_reg + 1'b1;
               sensor_trig_next = 1'b1;
            end
         end

         // Only a fresh rise starts timing; a level already high is ignored.
         // The rise cycle itself is the first high clock counted.
         WAIT_RISE: begin
            to_cnt_next = to_cnt_reg + 1'b1;
            if (to_expire) begin
               state_next   = IDLE;
               valid_next   = 1'b1;
               timeout_next = 1'b1;
               dist_next    = DIST_MAX;
            end else if (echo_rise) begin
               state_next = MEASURE;
               pre_next   = pre_step;
               acc_next   = acc_step;
            end
         end

         // A fall on the expiry cycle still reports a real measurement.
         MEASURE: begin
            to_cnt_next = to_cnt_reg + 1'b1;
            if (echo_fall) begin
               state_next = IDLE;
               valid_next = 1'b1;
               dist_next  = acc_reg;
            end else if (to_expire) begin
               state_next   = IDLE;
               valid_next   = 1'b1;
               timeout_next = 1'b1;
               dist_next    = DIST_MAX;
            end else if (echo_level) begin
               pre_next = pre_step;
               acc_next = acc_step;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         trig_cnt_reg    <= '0;
         to_cnt_reg      <= '0;
         pre_reg         <= '0;
         acc_reg         <= '0;
         dist_reg        <= '0;
         sensor_trig_reg <= 1'b0;
         suc_reg         <= 1'b0;
         valid_reg       <= 1'b0;
         timeout_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         trig_cnt_reg    <= trig_cnt_next;
         to_cnt_reg      <= to_cnt_next;
         pre_reg         <= pre_next;
         acc_reg         <= acc_next;
         dist_reg        <= dist_next;
         sensor_trig_reg <= sensor_trig_next;
         suc_reg         <= suc_next;
         valid_reg       <= valid_next;
         timeout_reg     <= timeout_next;
      end
   end

   assign sensor_trig    = sensor_trig_reg;
   assign bus.triggerSuc = suc_reg;
   assign bus.valid      = valid_reg;
   assign bus.timeout    = timeout_reg;
   assign bus.distance   = dist_reg;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger: trigger timing, floor boundaries,
// timeout, saturation and asynchronous reset, on several parameterisations.
module tb_sonar_ranger;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic trig_d, trig_t, trig_s;
   logic echo0, echo1, echo2, echo_t, echo_s;
   logic st0, st1, st2, st_t, st_s;

   int checks = 0;
   int errors = 0;
   int ack_at;
   int hi_cnt;

   sonar_ranger_if #(.DisLen(16)) bus0 ();
   sonar_ranger_if #(.DisLen(16)) bus1 ();
   sonar_ranger_if #(.DisLen(16)) bus2 ();
   sonar_ranger_if #(.DisLen(16)) bus_t ();
   sonar_ranger_if #(.DisLen(3))  bus_s ();

   assign bus0.trigger  = trig_d;
   assign bus1.trigger  = trig_d;
   assign bus2.trigger  = trig_d;
   assign bus_t.trigger = trig_t;
   assign bus_s.trigger = trig_s;

   sonar_ranger u_d0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .sensor_trig(st0), .echo(echo0));
   sonar_ranger u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .sensor_trig(st1), .echo(echo1));
   sonar_ranger u_d2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .sensor_trig(st2), .echo(echo2));
   sonar_ranger #(.TIMEOUT_CYCLES(2000)) u_to (
      .clk(clk), .rst_n(rst_n), .bus(bus_t), .sensor_trig(st_t), .echo(echo_t));
   sonar_ranger #(.DisLen(3), .CYC_PER_UNIT(10)) u_sat (
      .clk(clk), .rst_n(rst_n), .bus(bus_s), .sensor_trig(st_s), .echo(echo_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic suc_of(input int which);
      case (which)
         0:       return bus0.triggerSuc;
         3:       return bus_t.triggerSuc;
         default: return bus_s.triggerSuc;
      endcase
   endfunction

   // Bounded wait for the ack; returns 0 if it never came.
   task automatic wait_ack(input int which, output int cycles);
      cycles = 0;
      for (int i = 1; i <= 600; i++) begin
         tick(1);
         if (suc_of(which)) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      trig_d = 1'b0; trig_t = 1'b0; trig_s = 1'b0;
      echo0  = 1'b0; echo1  = 1'b0; echo2  = 1'b0; echo_t = 1'b0;
      echo_s = 1'b1;
      tick(3);
      chk("rst_sensor_trig", 32'(st0), 0);
      chk("rst_triggerSuc", 32'(bus0.triggerSuc), 0);
      chk("rst_valid", 32'(bus0.valid), 0);
      chk("rst_timeout", 32'(bus0.timeout), 0);
      chk("rst_distance", 32'(bus0.distance), 0);
      rst_n = 1'b1;
      tick(5);

      // Trigger pulse width and ack position.
      trig_d = 1'b1;
      ack_at = 0;
      hi_cnt = 0;
      for (int i = 1; i <= 600; i++) begin
         tick(1);
         if (bus0.triggerSuc) begin
            ack_at = i;
            break;
         end
         if (st0) hi_cnt++;
      end
      chk("ack_latency", 32'(ack_at), 501);
      chk("trig_high_cycles", 32'(hi_cnt), 500);
      chk("trig_low_at_ack", 32'(st0), 0);
      tick(1);
      trig_d = 1'b0;
      chk("ack_single_cycle", 32'(bus0.triggerSuc), 0);
      chk("no_retrigger", 32'(st0), 0);

      // Three echoes: 29200, 29491, 29492 high clocks.
      echo0 = 1'b1; echo1 = 1'b1; echo2 = 1'b1;
      tick(29200);
      echo0 = 1'b0;
      tick(2);
      chk("valid_not_early", 32'(bus0.valid), 0);
      tick(1);
      chk("valid_at_3", 32'(bus0.valid), 1);
      chk("timeout_clear", 32'(bus0.timeout), 0);
      chk("dist_29200", 32'(bus0.distance), 100);
      tick(1);
      chk("valid_one_cycle", 32'(bus0.valid), 0);
      chk("dist_held", 32'(bus0.distance), 100);
      tick(287);
      echo1 = 1'b0;
      tick(1);
      echo2 = 1'b0;
      tick(2);
      chk("valid_29491", 32'(bus1.valid), 1);
      chk("dist_29491", 32'(bus1.distance), 100);
      tick(1);
      chk("valid_29492", 32'(bus2.valid), 1);
      chk("dist_29492", 32'(bus2.distance), 101);

      // Timeout with TIMEOUT_CYCLES=2000 and no echo.
      trig_t = 1'b1;
      wait_ack(3, ack_at);
      chk("to_ack", 32'(ack_at), 501);
      tick(1);
      trig_t = 1'b0;
      tick(1998);
      chk("to_not_early", 32'(bus_t.valid), 0);
      tick(1);
      chk("to_valid", 32'(bus_t.valid), 1);
      chk("to_timeout", 32'(bus_t.timeout), 1);
      chk("to_distance", 32'(bus_t.distance), 32'h1FFFF);
      tick(1);
      chk("to_valid_drop", 32'(bus_t.valid), 0);
      chk("to_timeout_drop", 32'(bus_t.timeout), 0);
      trig_t = 1'b1;
      tick(1);
      chk("to_retrigger", 32'(st_t), 1);
      trig_t = 1'b0;

      // Saturation with DisLen=3, CYC_PER_UNIT=10; echo high since reset.
      trig_s = 1'b1;
      wait_ack(4, ack_at);
      chk("sat_ack", 32'(ack_at), 501);
      tick(1);
      trig_s = 1'b0;
      tick(48);
      echo_s = 1'b0;
      tick(3);
      chk("stale_echo_ignored", 32'(bus_s.valid), 0);
      tick(10);
      echo_s = 1'b1;
      tick(500);
      echo_s = 1'b0;
      tick(3);
      chk("sat_valid", 32'(bus_s.valid), 1);
      chk("sat_distance", 32'(bus_s.distance), 15);
      chk("sat_timeout", 32'(bus_s.timeout), 0);

      // Reset during MEASURE.
      trig_d = 1'b1;
      wait_ack(0, ack_at);
      chk("meas_ack", 32'(ack_at), 501);
      tick(1);
      trig_d = 1'b0;
      echo0 = 1'b1;
      tick(300);
      chk("meas_dist_held", 32'(bus0.distance), 100);
      #2 rst_n = 1'b0;
      #1;
      chk("meas_rst_distance", 32'(bus0.distance), 0);
      chk("meas_rst_valid", 32'(bus0.valid), 0);
      chk("meas_rst_sensor_trig", 32'(st0), 0);
      tick(1);
      echo0 = 1'b0;
      rst_n = 1'b1;
      tick(3);
      chk("no_valid_after_reset", 32'(bus0.valid), 0);

      // Reset during TRIG drops the pin without waiting for a clock.
      trig_d = 1'b1;
      tick(5);
      trig_d = 1'b0;
      chk("trig_before_reset", 32'(st0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_drop_trig", 32'(st0), 0);
      tick(1);
      rst_n = 1'b1;
      tick(2);
      trig_d = 1'b1;
      tick(1);
      chk("accept_after_reset", 32'(st0), 1);
      trig_d = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
